led_activity_scheduler: RTL and testbench

// Shares the single board activity LED among NUM_REQ status sources. Each source

---
 rtl/led_activity_scheduler.sv | 149 ++++++++++++++
 tb/tb_led_activity_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_activity_scheduler.sv
// Shares one activity LED among NUM_REQ status sources: a fixed-priority arbiter with a
// minimum hold time picks the owner, and a tick-driven sequencer renders its pattern.
module led_activity_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int CLK_HZ    = 100000000,
    parameter int TICK_HZ   = 1000,
    parameter int SLOW_HALF = 500,
    parameter int FAST_HALF = 125,
    parameter int PULSE_LEN = 50,
    parameter int MIN_HOLD  = 200
) (
    input  logic                   sysclk2,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [2*NUM_REQ-1:0]   req_mode,
    input  logic [NUM_REQ-1:0]     act_pulse,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   led,
    output logic                   tick
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PRE_W    = $clog2(PRESCALE) + 1;
    localparam int HOLD_W   = $clog2(MIN_HOLD) + 1;
    localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int PHASE_W  = $clog2(MAX_HALF) + 1;
    localparam int STR_W    = $clog2(PULSE_LEN) + 1;
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(MIN_HOLD);
    localparam logic [PHASE_W-1:0] SLOW_LAST = PHASE_W'(SLOW_HALF - 1);
    localparam logic [PHASE_W-1:0] FAST_LAST = PHASE_W'(FAST_HALF - 1);
    localparam logic [STR_W-1:0]   STR_LOAD  = STR_W'(PULSE_LEN);

    typedef enum logic {IDLE, OWN} state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   owner_idx, next_idx, low_idx;
    logic               any_valid, owner_valid, owner_act, grant_change;
    logic [1:0]         owner_mode;
    logic [PRE_W-1:0]   pre_cnt;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [PHASE_W-1:0] phase_cnt;
    logic [STR_W-1:0]   stretch_cnt;
    logic               blink_lvl, pattern_lvl, phase_last;

    // Lowest valid requester, plus the current owner's request lines.
    always_comb begin
        low_idx     = '0;
        any_valid   = 1'b0;
        owner_valid = 1'b0;
        owner_act   = 1'b0;
        owner_mode  = 2'b00;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                low_idx   = IDX_W'(i);
                any_valid = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_idx == IDX_W'(i)) begin
                owner_valid = req_valid[i];
                owner_act   = act_pulse[i];
                owner_mode  = req_mode[2*i +: 2];
            end
        end
    end

    // A dropped owner always re-arbitrates; a valid owner only yields to a lower index
    // once its hold time has elapsed.
    always_comb begin
        next_state = state;
        next_idx   = owner_idx;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    next_state = OWN;
                    next_idx   = low_idx;
                end
            end
            OWN: begin
                if (!owner_valid) begin
                    if (any_valid) next_idx = low_idx;
                    else           next_state = IDLE;
                end else if (low_idx < owner_idx && hold_cnt >= HOLD_MAX) begin
                    next_idx = low_idx;
                end
            end
            default: next_state = IDLE;
        endcase
        grant_change = (next_state != state) || (next_idx != owner_idx);
        phase_last   = owner_mode[0] ? (phase_cnt >= FAST_LAST) : (phase_cnt >= SLOW_LAST);
        case (owner_mode)
            2'b00:   pattern_lvl = 1'b0;
            2'b01:   pattern_lvl = 1'b1;
            default: pattern_lvl = blink_lvl;
        endcase
    end

    always_ff @(posedge sysclk2 or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner_idx   <= '0;
            grant       <= '0;
            pre_cnt     <= '0;
            tick        <= 1'b0;
            hold_cnt    <= '0;
            phase_cnt   <= '0;
            blink_lvl   <= 1'b0;
            stretch_cnt <= '0;
            led         <= 1'b0;
        end else begin
            if (pre_cnt == PRE_LAST) begin
                pre_cnt <= '0;
                tick    <= 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
                tick    <= 1'b0;
            end

            state     <= next_state;
            owner_idx <= next_idx;
            grant     <= (next_state == OWN) ? (NUM_REQ'(1) << next_idx) : '0;
            led       <= (state == OWN) && (pattern_lvl ^ (stretch_cnt != '0));

            // A new owner starts fresh: blink lit, no inherited activity stretch.
            if (grant_change) begin
                hold_cnt    <= '0;
                phase_cnt   <= '0;
                blink_lvl   <= 1'b1;
                stretch_cnt <= '0;
            end else begin
                if (tick && hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
                if (tick && owner_mode[1]) begin
                    if (phase_last) begin
                        phase_cnt <= '0;
                        blink_lvl <= ~blink_lvl;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                if (state == OWN && owner_act)       stretch_cnt <= STR_LOAD;
                else if (tick && stretch_cnt != '0) stretch_cnt <= stretch_cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_led_activity_scheduler.sv
// Self-checking bench for led_activity_scheduler: directed table, corner sequences and
// randomized traffic against a tick-level behavioural model.
module tb_led_activity_scheduler;

    localparam int NUM_REQ     = 4;
    localparam int CLK_HZ      = 1000;
    localparam int TICK_HZ     = 100;
    localparam int SLOW_HALF   = 4;
    localparam int FAST_HALF   = 2;
    localparam int PULSE_LEN   = 3;
    localparam int MIN_HOLD    = 5;
    localparam int TICK_PERIOD = CLK_HZ / TICK_HZ;

    logic       sysclk2   = 1'b0;
    logic       rst       = 1'b0;
    logic [3:0] req_valid = '0;
    logic [7:0] req_mode  = '0;
    logic [3:0] act_pulse = '0;
    logic [3:0] grant;
    logic       led;
    logic       tick;

    led_activity_scheduler #(
        .NUM_REQ(NUM_REQ), .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .SLOW_HALF(SLOW_HALF),
        .FAST_HALF(FAST_HALF), .PULSE_LEN(PULSE_LEN), .MIN_HOLD(MIN_HOLD)
    ) dut (
        .sysclk2(sysclk2), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
        .act_pulse(act_pulse), .grant(grant), .led(led), .tick(tick)
    );

    always #5 sysclk2 = ~sysclk2;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: owner (-1 idle), ticks held, ticks into current half, lit level,
    // remaining stretch ticks, cycles since reset release.
    int m_owner = -1;
    int m_hold, m_phase, m_stretch, m_cyc;
    bit m_lit, m_tick, m_led;

    typedef struct {
        logic [3:0] valid;
        logic [7:0] mode;
        logic [3:0] act;
        int         cycles;
        logic [3:0] exp_grant;
        logic       exp_led;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] mode,
                                 input logic [3:0] act);
        req_valid = valid;
        req_mode  = mode;
        act_pulse = act;
    endtask

    function automatic int modeOf(input int k);
        return int'(req_mode[2*k +: 2]);
    endfunction

    task automatic modelReset();
        m_owner = -1; m_hold = 0; m_phase = 0; m_stretch = 0; m_cyc = 0;
        m_lit = 1'b0; m_tick = 1'b0; m_led = 1'b0;
    endtask

    task automatic modelStep();
        int  lowest = -1;
        int  next_owner;
        int  md = 0;
        bit  pat;
        bit  t = m_tick;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (req_valid[i]) lowest = i;
        if (m_owner < 0) begin
            m_led = 1'b0;
        end else begin
            md    = modeOf(m_owner);
            pat   = (md == 0) ? 1'b0 : (md == 1) ? 1'b1 : m_lit;
            m_led = pat ^ (m_stretch > 0);
        end
        next_owner = m_owner;
        if (m_owner < 0 || !req_valid[m_owner]) next_owner = lowest;
        else if (lowest >= 0 && lowest < m_owner && m_hold >= MIN_HOLD) next_owner = lowest;
        if (next_owner != m_owner) begin
            m_owner = next_owner; m_hold = 0; m_phase = 0; m_lit = 1'b1; m_stretch = 0;
        end else if (m_owner >= 0) begin
            if (t && m_hold < MIN_HOLD) m_hold++;
            if (t && md >= 2) begin
                m_phase++;
                if (m_phase >= ((md == 2) ? SLOW_HALF : FAST_HALF)) begin
                    m_phase = 0;
                    m_lit   = ~m_lit;
                end
            end
            if (act_pulse[m_owner]) m_stretch = PULSE_LEN;
            else if (t && m_stretch > 0) m_stretch--;
        end
        m_cyc++;
        m_tick = (m_cyc % TICK_PERIOD == 0);
    endtask

    task automatic stepCycle();
        logic [3:0] exp_grant;
        @(posedge sysclk2);
        modelStep();
        #1;
        exp_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        checkOutput($sformatf("cyc%0d_grant", m_cyc), {28'b0, grant}, {28'b0, exp_grant});
        checkOutput($sformatf("cyc%0d_led", m_cyc), {31'b0, led}, {31'b0, m_led});
        checkOutput($sformatf("cyc%0d_tick", m_cyc), {31'b0, tick}, {31'b0, m_tick});
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases just after an edge.
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_grant", {28'b0, grant}, 32'd0);
        checkOutput("rst_led", {31'b0, led}, 32'd0);
        checkOutput("rst_tick", {31'b0, tick}, 32'd0);
        @(posedge sysclk2);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic       led_hist[0:120];
        int         run_hi, run_lo, first_tick;
        logic [3:0] rv, ra;
        logic [7:0] rm;

        vecs[0]  = '{4'b0000, 8'h00,        4'b0000, 3, 4'b0000, 1'b0};
        vecs[1]  = '{4'b0001, 8'b0000_0001, 4'b0000, 1, 4'b0001, 1'b0};
        vecs[2]  = '{4'b0001, 8'b0000_0001, 4'b0000, 1, 4'b0001, 1'b1};
        vecs[3]  = '{4'b0000, 8'b0000_0001, 4'b0000, 1, 4'b0000, 1'b1};
        vecs[4]  = '{4'b0000, 8'b0000_0001, 4'b0000, 1, 4'b0000, 1'b0};
        vecs[5]  = '{4'b0010, 8'h00,        4'b0000, 2, 4'b0010, 1'b0};
        vecs[6]  = '{4'b0010, 8'b0000_0100, 4'b0000, 1, 4'b0010, 1'b1};
        vecs[7]  = '{4'b0011, 8'b0000_0101, 4'b0000, 1, 4'b0010, 1'b1};
        vecs[8]  = '{4'b0001, 8'b0000_0101, 4'b0000, 1, 4'b0001, 1'b1};
        vecs[9]  = '{4'b0001, 8'b0000_0101, 4'b0001, 1, 4'b0001, 1'b1};
        vecs[10] = '{4'b0001, 8'b0000_0101, 4'b0000, 1, 4'b0001, 1'b0};
        vecs[11] = '{4'b1000, 8'b1000_0101, 4'b0000, 1, 4'b1000, 1'b0};
        vecs[12] = '{4'b1000, 8'b1000_0101, 4'b0000, 1, 4'b1000, 1'b1};

        #2;
        doReset();

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].mode, vecs[i].act);
            stepCycle();
            act_pulse = 4'b0000;
            for (int n = 1; n < vecs[i].cycles; n++) stepCycle();
            checkOutput($sformatf("vec%0d_grant", i), {28'b0, grant}, {28'b0, vecs[i].exp_grant});
            checkOutput($sformatf("vec%0d_led", i), {31'b0, led}, {31'b0, vecs[i].exp_led});
        end

        // Slow blink: lit for 4 ticks, dark for 4 ticks.
        doReset();
        applyStimulus(4'b0001, 8'b0000_0010, 4'b0000);
        for (int c = 1; c <= 120; c++) begin
            stepCycle();
            led_hist[c] = led;
        end
        run_hi = 0;
        for (int i = 2; i <= 120 && led_hist[i] == 1'b1; i++) run_hi++;
        run_lo = 0;
        for (int i = 2 + run_hi; i <= 120 && led_hist[i] == 1'b0; i++) run_lo++;
        checkOutput("slow_led_before_lit", {31'b0, led_hist[1]}, 32'd0);
        checkOutput("slow_high_run", run_hi, 32'd40);
        checkOutput("slow_low_run", run_lo, 32'd40);

        // Reset mid-blink while tick is high, then time the first tick after release.
        #3;
        doReset();
        first_tick = -1;
        for (int c = 1; c <= 12; c++) begin
            stepCycle();
            if (tick && first_tick < 0) first_tick = c;
        end
        checkOutput("first_tick_cycle", first_tick, 32'd10);

        // Preemption waits for the hold time; blink restarts lit on the new owner.
        doReset();
        applyStimulus(4'b0100, 8'b1010_1010, 4'b0000);
        for (int c = 1; c <= 60; c++) begin
            stepCycle();
            if (c == 51) checkOutput("preempt_hold_grant", {28'b0, grant}, 32'h4);
            if (c == 52) checkOutput("preempt_grant", {28'b0, grant}, 32'h1);
            if (c == 53) checkOutput("preempt_blink_lit", {31'b0, led}, 32'd1);
            if (c == 12) req_valid = 4'b1101;
        end

        // A higher index never preempts; then owner drop with 0 and 3 valid picks 0.
        doReset();
        applyStimulus(4'b0010, 8'b0101_0101, 4'b0000);
        for (int c = 1; c <= 70; c++) begin
            stepCycle();
            if (c == 2) req_valid = 4'b1010;
        end
        checkOutput("no_high_preempt", {28'b0, grant}, 32'h2);
        req_valid = 4'b1001;
        stepCycle();
        checkOutput("simul_drop_grant", {28'b0, grant}, 32'h1);

        // Activity stretch, retrigger, and a pulse from a non-owner.
        doReset();
        applyStimulus(4'b0011, 8'b0000_0101, 4'b0000);
        for (int c = 1; c <= 64; c++) begin
            stepCycle();
            if (c == 5)  checkOutput("act_led_before", {31'b0, led}, 32'd1);
            if (c == 6)  checkOutput("act_led_dark", {31'b0, led}, 32'd0);
            if (c == 32) checkOutput("act_retrigger_extends", {31'b0, led}, 32'd0);
            if (c == 51) checkOutput("act_still_dark", {31'b0, led}, 32'd0);
            if (c == 52) checkOutput("act_led_restored", {31'b0, led}, 32'd1);
            if (c == 62) checkOutput("act_nonowner_ignored", {31'b0, led}, 32'd1);
            act_pulse = (c == 4 || c == 21) ? 4'b0001 : (c == 59) ? 4'b0010 : 4'b0000;
        end

        // Randomized traffic against the model, with one mid-run asynchronous reset.
        doReset();
        rv = '0; rm = '0; ra = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 39) == 0) rv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 15) == 0) rm = 8'($urandom);
            ra = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            applyStimulus(rv, rm, ra);
            stepCycle();
            if (n == 1500) begin
                #2;
                doReset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
